// File: rtl/seg_display_scanner_pkg.sv
// Shared constants and types for the 7-segment display scanner.
package seg_display_pkg;

  localparam logic [6:0] SEG_ZERO  = 7'b0111111;
  localparam logic [6:0] SEG_MINUS = 7'b1000000;
  localparam logic [6:0] SEG_OFF   = 7'b0000000;

  typedef enum logic {
    BLANK,
    SHOW
  } scan_state_t;

  typedef logic [1:0] digit_idx_t;

  // One-hot anode enable for a digit index; [3]=sign ... [0]=units.
  function automatic logic [3:0] digit_onehot(digit_idx_t idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/seg_display_scanner_if.sv
// Data bus between the decoder side and the display scanner.
interface seg_display_scanner_if #(
  parameter int unsigned SEGMENT_WIDTH = 7
);

  logic                     load;
  logic                     sign;
  logic [SEGMENT_WIDTH-1:0] segments_hundreds;
  logic [SEGMENT_WIDTH-1:0] segments_tens;
  logic [SEGMENT_WIDTH-1:0] segments_units;
  logic [SEGMENT_WIDTH-1:0] seg_out;
  logic [3:0]               digit_en;
  logic                     frame_done;

  modport master (
    output load,
    output sign,
    output segments_hundreds,
    output segments_tens,
    output segments_units,
    input  seg_out,
    input  digit_en,
    input  frame_done
  );

  modport slave (
    input  load,
    input  sign,
    input  segments_hundreds,
    input  segments_tens,
    input  segments_units,
    output seg_out,
    output digit_en,
    output frame_done
  );

endinterface

// File: rtl/seg_display_scanner_timer.sv
// Slot timer: counts clk cycles inside each digit slot, steps the digit
// index 3->2->1->0->3 and flags the blanking window and the frame end.
module digit_slot_timer
  import seg_display_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned CNT_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt,
  output digit_idx_t       idx,
  output logic             in_blank,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam scan_state_t      RST_STATE = (BLANK_CYCLES > 0) ? BLANK : SHOW;

  scan_state_t      state;
  scan_state_t      state_next;
  logic [CNT_W-1:0] cnt_next;
  digit_idx_t       idx_next;
  logic             frame_done_next;

  // Next slot position; state and frame flag are decoded from the next
  // count so they line up with cnt/idx instead of lagging a cycle.
  always_comb begin
    cnt_next        = cnt + 1'b1;
    idx_next        = idx;
    if (cnt == CNT_LAST) begin
      cnt_next = '0;
      idx_next = idx - 1'b1;
    end
    state_next      = (cnt_next < CNT_BLANK) ? BLANK : SHOW;
    frame_done_next = (cnt_next == CNT_LAST) && (idx_next == 2'd0);
  end

  // Slot position and scan state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= 2'd3;
      state      <= RST_STATE;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      idx        <= idx_next;
      state      <= state_next;
      frame_done <= frame_done_next;
    end
  end

  assign in_blank = (state == BLANK);

endmodule

// File: rtl/seg_display_scanner.sv
// Four-digit 7-segment scanner (sign, hundreds, tens, units) on one shared
// segment bus, with per-slot blanking and frame-aligned double buffering.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg_display_scanner
  import seg_display_pkg::*;
#(
  parameter int unsigned SEGMENT_WIDTH = 7,
  parameter int unsigned CLK_DIV       = 50000,
  parameter int unsigned BLANK_CYCLES  = 16,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg_display_scanner_if.slave  bus
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [SEGMENT_WIDTH-1:0] PAT_ZERO  = SEGMENT_WIDTH'(SEG_ZERO);
  localparam logic [SEGMENT_WIDTH-1:0] PAT_MINUS = SEGMENT_WIDTH'(SEG_MINUS);
  localparam logic [SEGMENT_WIDTH-1:0] PAT_OFF   = SEGMENT_WIDTH'(SEG_OFF);
  localparam logic [SEGMENT_WIDTH-1:0] SEG_POL   = ACTIVE_LOW ? '1 : '0;
  localparam logic [3:0]               EN_POL    = ACTIVE_LOW ? '1 : '0;

  logic [CNT_W-1:0] tmr_cnt;
  digit_idx_t       tmr_idx;
  logic             tmr_in_blank;
  logic             frame_boundary;

  digit_slot_timer #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt        (tmr_cnt),
    .idx        (tmr_idx),
    .in_blank   (tmr_in_blank),
    .frame_done (frame_boundary)
  );

  // Slot count is exposed by the timer for debug; the mux only needs the
  // blank flag and index.
  logic unused_cnt;
  assign unused_cnt = ^tmr_cnt;

  logic                     pend_valid;
  logic                     pend_sign;
  logic [SEGMENT_WIDTH-1:0] pend_hundreds;
  logic [SEGMENT_WIDTH-1:0] pend_tens;
  logic [SEGMENT_WIDTH-1:0] pend_units;
  logic                     disp_sign;
  logic [SEGMENT_WIDTH-1:0] disp_hundreds;
  logic [SEGMENT_WIDTH-1:0] disp_tens;
  logic [SEGMENT_WIDTH-1:0] disp_units;

  // Double buffer: loads park in pending and are promoted only at the frame
  // boundary; a load landing exactly on the boundary goes straight to display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid    <= 1'b0;
      pend_sign     <= 1'b0;
      pend_hundreds <= '0;
      pend_tens     <= '0;
      pend_units    <= '0;
      disp_sign     <= 1'b0;
      disp_hundreds <= '0;
      disp_tens     <= '0;
      disp_units    <= '0;
    end else if (frame_boundary) begin
      if (bus.load) begin
        disp_sign     <= bus.sign;
        disp_hundreds <= bus.segments_hundreds;
        disp_tens     <= bus.segments_tens;
        disp_units    <= bus.segments_units;
      end else if (pend_valid) begin
        disp_sign     <= pend_sign;
        disp_hundreds <= pend_hundreds;
        disp_tens     <= pend_tens;
        disp_units    <= pend_units;
      end
      pend_valid <= 1'b0;
    end else if (bus.load) begin
      pend_sign     <= bus.sign;
      pend_hundreds <= bus.segments_hundreds;
      pend_tens     <= bus.segments_tens;
      pend_units    <= bus.segments_units;
      pend_valid    <= 1'b1;
    end
  end

  logic hundreds_blank;
  logic tens_blank;

`ifdef LEADING_ZERO_BLANK_EN
  assign hundreds_blank = (disp_hundreds == PAT_ZERO);
  assign tens_blank     = hundreds_blank && (disp_tens == PAT_ZERO);
`else
  assign hundreds_blank = 1'b0;
  assign tens_blank     = 1'b0;
`endif

  logic [SEGMENT_WIDTH-1:0] slot_pat;
  logic [3:0]               slot_en;

  // Pattern and anode select for the current slot; all off while blanking.
  always_comb begin
    slot_pat = PAT_OFF;
    slot_en  = 4'b0000;
    if (!tmr_in_blank) begin
      slot_en = digit_onehot(tmr_idx);
      case (tmr_idx)
        2'd3:    slot_pat = disp_sign ? PAT_MINUS : PAT_OFF;
        2'd2:    slot_pat = hundreds_blank ? PAT_OFF : disp_hundreds;
        2'd1:    slot_pat = tens_blank ? PAT_OFF : disp_tens;
        default: slot_pat = disp_units;
      endcase
    end
  end

  logic [SEGMENT_WIDTH-1:0] seg_q;
  logic [3:0]               en_q;

  // Output registers; polarity inversion is the only active-low stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_POL;
      en_q  <= EN_POL;
    end else begin
      seg_q <= slot_pat ^ SEG_POL;
      en_q  <= slot_en ^ EN_POL;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.digit_en   = en_q;
  assign bus.frame_done = frame_boundary;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Bench for seg_display_scanner: an active-high and an active-low instance
// driven in parallel, checked every cycle against a frame-position model,
// plus directed literal checks of reset, timing and buffering scenarios.
module tb_seg_display_scanner;

  localparam int unsigned W     = 7;
  localparam int unsigned DIV   = 8;
  localparam int unsigned BLK   = 2;
  localparam int unsigned FRAME = 4 * DIV;

  localparam logic [6:0] ZERO7  = 7'b0111111;
  localparam logic [6:0] MINUS7 = 7'b1000000;
  localparam logic [6:0] H1     = 7'b0000110;
  localparam logic [6:0] D2     = 7'b1011011;
  localparam logic [6:0] D3     = 7'b1001111;
  localparam logic [6:0] D5     = 7'b1101101;
  localparam logic [6:0] D7     = 7'b0000111;
  localparam logic [6:0] D8     = 7'b1111111;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       load = 1'b0;
  logic       sign = 1'b0;
  logic [6:0] h_in = '0;
  logic [6:0] t_in = '0;
  logic [6:0] u_in = '0;

  int errors = 0;
  int checks = 0;

  seg_display_scanner_if #(.SEGMENT_WIDTH(W)) bus_a ();
  seg_display_scanner_if #(.SEGMENT_WIDTH(W)) bus_b ();

  assign bus_a.load              = load;
  assign bus_a.sign              = sign;
  assign bus_a.segments_hundreds = h_in;
  assign bus_a.segments_tens     = t_in;
  assign bus_a.segments_units    = u_in;
  assign bus_b.load              = load;
  assign bus_b.sign              = sign;
  assign bus_b.segments_hundreds = h_in;
  assign bus_b.segments_tens     = t_in;
  assign bus_b.segments_units    = u_in;

  seg_display_scanner #(
    .SEGMENT_WIDTH (W),
    .CLK_DIV       (DIV),
    .BLANK_CYCLES  (BLK),
    .ACTIVE_LOW    (1'b0)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  seg_display_scanner #(
    .SEGMENT_WIDTH (W),
    .CLK_DIV       (DIV),
    .BLANK_CYCLES  (BLK),
    .ACTIVE_LOW    (1'b1)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_pos is the position inside the 32-cycle frame of the state the DUT
  // holds before the next clock edge (0 = first cycle of the sign slot).
  int         m_pos;
  bit         m_pvalid;
  logic       m_psign, m_dsign;
  logic [6:0] m_ph, m_pt, m_pu, m_dh, m_dt, m_du;
  logic [6:0] exp_seg;
  logic [3:0] exp_en;
  logic       exp_fd;

  function automatic logic [6:0] slot_pattern(input int slot, input logic s,
                                               input logic [6:0] h, input logic [6:0] t,
                                               input logic [6:0] u);
    bit h_blank;
    bit t_blank;
    h_blank = LZB && (h == ZERO7);
    t_blank = h_blank && (t == ZERO7);
    case (slot)
      3:       return s ? MINUS7 : 7'b0;
      2:       return h_blank ? 7'b0 : h;
      1:       return t_blank ? 7'b0 : t;
      default: return u;
    endcase
  endfunction

  task automatic model_reset();
    m_pos = 0;
    m_pvalid = 0;
    {m_psign, m_ph, m_pt, m_pu} = '0;
    {m_dsign, m_dh, m_dt, m_du} = '0;
    exp_seg = '0;
    exp_en  = '0;
    exp_fd  = 1'b0;
  endtask

  // Advances the model across one clock edge using the inputs held for it.
  task automatic model_step();
    int slot;
    int c;
    slot = 3 - m_pos / DIV;
    c    = m_pos % DIV;
    if (c < BLK) begin
      exp_seg = '0;
      exp_en  = '0;
    end else begin
      exp_en  = 4'b0001 << slot;
      exp_seg = slot_pattern(slot, m_dsign, m_dh, m_dt, m_du);
    end
    if (m_pos == FRAME - 1) begin
      if (load) {m_dsign, m_dh, m_dt, m_du} = {sign, h_in, t_in, u_in};
      else if (m_pvalid) {m_dsign, m_dh, m_dt, m_du} = {m_psign, m_ph, m_pt, m_pu};
      m_pvalid = 0;
    end else if (load) begin
      {m_psign, m_ph, m_pt, m_pu} = {sign, h_in, t_in, u_in};
      m_pvalid = 1;
    end
    m_pos  = (m_pos + 1) % FRAME;
    exp_fd = (m_pos == FRAME - 1);
  endtask

  // Compare on the falling edge, then advance the model for the next rise.
  initial begin
    logic [6:0] es;
    logic [3:0] ee;
    logic       ef;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        es = '0;
        ee = '0;
        ef = 1'b0;
      end else begin
        es = exp_seg;
        ee = exp_en;
        ef = exp_fd;
      end
      chk("model_seg_a", bus_a.seg_out, es);
      chk("model_en_a", bus_a.digit_en, ee);
      chk("model_fd_a", bus_a.frame_done, ef);
      chk("model_seg_b", bus_b.seg_out, es ^ 7'h7F);
      chk("model_en_b", bus_b.digit_en, ee ^ 4'hF);
      chk("model_fd_b", bus_b.frame_done, ef);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- directed stimulus ----------------
  logic [6:0] cap_a [4];
  logic [6:0] cap_b [4];
  logic [3:0] cap_en[4];

  task automatic pulse_load(input logic s, input logic [6:0] h, input logic [6:0] t,
                            input logic [6:0] u);
    load = 1'b1;
    sign = s;
    h_in = h;
    t_in = t;
    u_in = u;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic wait_fd(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus_a.frame_done) seen = 1;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  // Entered just after the boundary edge; records one mid-slot sample per digit.
  task automatic capture_rest();
    for (int e = 0; e < 32; e++) begin
      @(posedge clk);
      #1;
      if (e % 8 == 4) begin
        cap_a[3 - e / 8]  = bus_a.seg_out;
        cap_b[3 - e / 8]  = bus_b.seg_out;
        cap_en[3 - e / 8] = bus_a.digit_en;
      end
    end
  endtask

  task automatic capture_frame(input string name);
    wait_fd({name, "_fd"});
    @(posedge clk);
    #1;
    capture_rest();
  endtask

  task automatic check_frame(input string name, input logic [3:0][6:0] e);
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("%s_a%0d", name, s), cap_a[s], e[s]);
      chk($sformatf("%s_b%0d", name, s), cap_b[s], e[s] ^ 7'h7F);
      chk($sformatf("%s_en%0d", name, s), cap_en[s], 4'b0001 << s);
    end
  endtask

  initial begin
    logic [3:0] en_exp;
    bit         found;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_seg_a", bus_a.seg_out, 7'h00);
    chk("rst_en_a", bus_a.digit_en, 4'h0);
    chk("rst_seg_b", bus_b.seg_out, 7'h7F);
    chk("rst_en_b", bus_b.digit_en, 4'hF);
    chk("rst_fd", bus_a.frame_done, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset asserted in the middle of the hundreds SHOW window.
    repeat (12) @(posedge clk);
    #1;
    chk("pre_rst_en_a", bus_a.digit_en, 4'b0100);
    rst_n = 1'b0;
    #1;
    chk("async_seg_a", bus_a.seg_out, 7'h00);
    chk("async_en_a", bus_a.digit_en, 4'h0);
    chk("async_seg_b", bus_b.seg_out, 7'h7F);
    chk("async_en_b", bus_b.digit_en, 4'hF);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Frame restarts at the sign slot; frame_done at edges 31 and 63.
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk);
      #1;
      if (k <= 10) begin
        en_exp = (k >= 3 && k <= 8) ? 4'b1000 : 4'b0000;
        chk($sformatf("t1_en_k%0d", k), bus_a.digit_en, en_exp);
      end
      if (k == 31 || k == 63) chk($sformatf("t2_fd_k%0d", k), bus_a.frame_done, 1'b1);
    end

    // -128 loaded mid-frame: remainder of this frame keeps the old (blank) value.
    repeat (10) @(posedge clk);
    #1;
    pulse_load(1'b1, H1, D2, D8);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if (bus_a.digit_en == 4'b0001) found = 1;
    end
    chk("t3_units_slot_seen", 32'(found), 32'd1);
    chk("t3_cur_units", bus_a.seg_out, 7'h00);
    capture_frame("t3");
    check_frame("t3_next", {MINUS7, H1, D2, D8});

    // Two loads in one frame: only the later one is displayed.
    repeat (3) @(posedge clk);
    #1;
    pulse_load(1'b0, ZERO7, ZERO7, D5);
    repeat (5) @(posedge clk);
    #1;
    pulse_load(1'b1, ZERO7, ZERO7, D7);
    capture_frame("t4");
    check_frame("t4_last", {MINUS7, LZB ? 7'h00 : ZERO7, LZB ? 7'h00 : ZERO7, D7});

    // Pending value overridden by a load on the boundary cycle (bypass);
    // the frame after must still show the bypassed value.
    repeat (5) @(posedge clk);
    #1;
    pulse_load(1'b1, H1, D2, D8);
    wait_fd("t4_byp_fd");
    pulse_load(1'b0, H1, D2, D3);
    capture_rest();
    check_frame("t4_byp", {7'h00, H1, D2, D3});
    capture_frame("t4_hold");
    check_frame("t4_hold", {7'h00, H1, D2, D3});

    // +5 and +25: leading-zero handling.
    pulse_load(1'b0, ZERO7, ZERO7, D5);
    capture_frame("t5a");
    check_frame("t5_p5", {7'h00, LZB ? 7'h00 : ZERO7, LZB ? 7'h00 : ZERO7, D5});
    pulse_load(1'b0, ZERO7, D2, D5);
    capture_frame("t5b");
    check_frame("t5_p25", {7'h00, LZB ? 7'h00 : ZERO7, D2, D5});

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, got t=%0t required < 200000", $time);
    $fatal(1, "watchdog");
  end

endmodule
